regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 77 +++++++
 rtl/regfile_mp.sv | 84 ++++++++
 tb/tb_regfile_mp.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, port-count limits and word/address types for the
// multi-ported register file. No ports; imported by regfile_mp and regfile_scoreboard.
package regfile_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_NUM_RD     = 2;
    localparam int RF_NUM_WR     = 2;

    // Supported port-count ranges.
    localparam int RF_MIN_RD = 1;
    localparam int RF_MAX_RD = 4;
    localparam int RF_MIN_WR = 1;
    localparam int RF_MAX_WR = 2;

    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: one busy bit per register, reservation accept,
// flush and a registered population count of the busy bits.
// Ports: clk, reset_n (async, active-low), wr_en/wr_addr (completing writes),
//        rsv_en/rsv_addr (destination reservation), flush,
//        pending (busy bits), rsv_ok, pending_cnt.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_WR     = RF_NUM_WR
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_WR-1:0]                    wr_en,
    input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]    wr_addr,
    input  logic                                 rsv_en,
    input  logic [ADDR_WIDTH-1:0]                rsv_addr,
    input  logic                                 flush,
    output logic [(2**ADDR_WIDTH)-1:0]           pending,
    output logic                                 rsv_ok,
    output logic [ADDR_WIDTH:0]                  pending_cnt
);

    localparam int NREGS = 2**ADDR_WIDTH;

    logic [NREGS-1:0]  r_pending;
    logic [NREGS-1:0]  w_pend_nxt;
    logic [ADDR_WIDTH:0] r_cnt;
    logic [ADDR_WIDTH:0] w_cnt_nxt;
    logic              w_wr_hit;

    always_comb begin
        w_wr_hit = 1'b0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w] == rsv_addr)) begin
                w_wr_hit = 1'b1;
            end
        end
        // A register that completes this cycle may be reserved again.
        rsv_ok = (rsv_addr == '0) || !r_pending[rsv_addr] || w_wr_hit;
    end

    // Order matters: flush, then write clears, then the reservation,
    // so a new producer always wins over both.
    always_comb begin
        w_pend_nxt = flush ? '0 : r_pending;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
                w_pend_nxt[wr_addr[w]] = 1'b0;
            end
        end
        if (rsv_en && rsv_ok && (rsv_addr != '0)) begin
            w_pend_nxt[rsv_addr] = 1'b1;
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_cnt_nxt = w_cnt_nxt + {{ADDR_WIDTH{1'b0}}, w_pend_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_cnt     <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign pending     = r_pending;
    assign pending_cnt = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with x0 hard-wired to zero and a pending
// scoreboard. Optional write-to-read bypass: define REGFILE_BYPASS_EN.
// Ports: clk, reset_n (async, active-low), rd_addr/rd_data/rd_ready (read
//        ports), wr_en/wr_addr/wr_data (write ports), rsv_en/rsv_addr/rsv_ok
//        (reservation), flush, pending_cnt.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_RD     = RF_NUM_RD,
    parameter int NUM_WR     = RF_NUM_WR
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    rd_addr,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_RD-1:0]                    rd_ready,
    input  logic [NUM_WR-1:0]                    wr_en,
    input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]    wr_addr,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wr_data,
    input  logic                                 rsv_en,
    input  logic [ADDR_WIDTH-1:0]                rsv_addr,
    output logic                                 rsv_ok,
    input  logic                                 flush,
    output logic [ADDR_WIDTH:0]                  pending_cnt
);

    localparam int NREGS = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [NREGS];
    logic [NREGS-1:0]      w_pending;

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WR     (NUM_WR)
    ) u_sb (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .flush       (flush),
        .pending     (w_pending),
        .rsv_ok      (rsv_ok),
        .pending_cnt (pending_cnt)
    );

    // Later ports overwrite earlier ones on an address collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && (wr_addr[w] != '0)) begin
                    r_regs[wr_addr[w]] <= wr_data[w];
                end
            end
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_data[r]  = (rd_addr[r] == '0) ? '0 : r_regs[rd_addr[r]];
            rd_ready[r] = !w_pending[rd_addr[r]];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is held off in reset so reads stay zero.
            for (int w = 0; w < NUM_WR; w++) begin
                if (reset_n && wr_en[w] && (rd_addr[r] != '0) &&
                    (wr_addr[w] == rd_addr[r])) begin
                    rd_data[r]  = wr_data[w];
                    rd_ready[r] = 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;
    import regfile_pkg::*;

    logic             clk;
    logic             reset_n;
    logic [1:0][4:0]  rd_addr;
    logic [1:0][31:0] rd_data;
    logic [1:0]       rd_ready;
    logic [1:0]       wr_en;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic             rsv_en;
    logic [4:0]       rsv_addr;
    logic             rsv_ok;
    logic             flush;
    logic [5:0]       pending_cnt;

    int n_chk;
    int n_err;
    logic [31:0] sb_q [$];

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [6];
    vec_t v;

    regfile_mp dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .rsv_ok      (rsv_ok),
        .flush       (flush),
        .pending_cnt (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 2'b00;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic sb_cmp(input string name, input logic [31:0] act);
        logic [31:0] e;
        if (sb_q.size() == 0) begin
            chk({name, "_empty_q"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk(name, act, e);
        end
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_addr = '0;
        idle();

        vecs[0] = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,
                    5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{2'b01, 5'd0,  32'h00001234, 5'd0,  32'h0,
                    5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        vecs[2] = '{2'b11, 5'd7,  32'h00000011, 5'd7,  32'h00000022,
                    5'd7,  5'd7,  32'h00000022, 32'h00000022};
        vecs[3] = '{2'b11, 5'd10, 32'hAAAA0000, 5'd11, 32'h0000BBBB,
                    5'd10, 5'd11, 32'hAAAA0000, 32'h0000BBBB};
        vecs[4] = '{2'b10, 5'd0,  32'h0,        5'd5,  32'hCAFEF00D,
                    5'd5,  5'd10, 32'hCAFEF00D, 32'hAAAA0000};
        vecs[5] = '{2'b11, 5'd31, 32'hFFFFFFFF, 5'd1,  32'h00000001,
                    5'd31, 5'd1,  32'hFFFFFFFF, 32'h00000001};

        // Reset state
        #2;
        rd_addr[0] = 5'd5;
        rd_addr[1] = 5'd31;
        #1;
        chk("rst_rd0", rd_data[0], 32'h0);
        chk("rst_rd1", rd_data[1], 32'h0);
        chk("rst_ready", {30'd0, rd_ready}, 32'd3);
        chk("rst_cnt", {26'd0, pending_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        step();

        // Table: write in one cycle, read back the next
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            wr_en      = v.we;
            wr_addr[0] = v.wa0;
            wr_data[0] = v.wd0;
            wr_addr[1] = v.wa1;
            wr_data[1] = v.wd1;
            sb_q.push_back(v.e0);
            sb_q.push_back(v.e1);
            step();
            wr_en      = 2'b00;
            rd_addr[0] = v.ra0;
            rd_addr[1] = v.ra1;
            #1;
            sb_cmp($sformatf("vec%0d_rd0", i), rd_data[0]);
            sb_cmp($sformatf("vec%0d_rd1", i), rd_data[1]);
            chk($sformatf("vec%0d_ready", i), {30'd0, rd_ready}, 32'd3);
        end

        // Reserve / complete / dropped re-reserve on x3
        rsv_en   = 1'b1;
        rsv_addr = 5'd3;
        #1;
        chk("rsv3_ok", {31'd0, rsv_ok}, 32'd1);
        step();
        idle();
        rd_addr[0] = 5'd3;
        #1;
        chk("rsv3_ready", {31'd0, rd_ready[0]}, 32'd0);
        chk("rsv3_cnt", {26'd0, pending_cnt}, 32'd1);
        rsv_en = 1'b1;
        #1;
        chk("rsv3_again_ok", {31'd0, rsv_ok}, 32'd0);
        step();
        idle();
        chk("rsv3_again_cnt", {26'd0, pending_cnt}, 32'd1);
        wr_en      = 2'b01;
        wr_addr[0] = 5'd3;
        wr_data[0] = 32'h00000033;
        #1;
        chk("rsv3_wr_ok", {31'd0, rsv_ok}, 32'd1);
        step();
        idle();
        #1;
        chk("wr3_ready", {31'd0, rd_ready[0]}, 32'd1);
        chk("wr3_cnt", {26'd0, pending_cnt}, 32'd0);
        chk("wr3_data", rd_data[0], 32'h00000033);

        // Write and reservation of the same pending register
        rsv_en   = 1'b1;
        rsv_addr = 5'd12;
        step();
        idle();
        wr_en      = 2'b10;
        wr_addr[1] = 5'd12;
        wr_data[1] = 32'h12121212;
        rsv_en     = 1'b1;
        #1;
        chk("rsv12_wr_ok", {31'd0, rsv_ok}, 32'd1);
        step();
        idle();
        rd_addr[0] = 5'd12;
        #1;
        chk("rsv12_still", {31'd0, rd_ready[0]}, 32'd0);
        chk("rsv12_cnt", {26'd0, pending_cnt}, 32'd1);
        chk("rsv12_data", rd_data[0], 32'h12121212);
        wr_en = 2'b10;
        step();
        idle();
        chk("wr12_cnt", {26'd0, pending_cnt}, 32'd0);

        // Flush with a same-cycle reservation
        rsv_en   = 1'b1;
        rsv_addr = 5'd4;
        step();
        rsv_addr = 5'd6;
        step();
        idle();
        chk("rsv46_cnt", {26'd0, pending_cnt}, 32'd2);
        flush    = 1'b1;
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        step();
        idle();
        rd_addr[0] = 5'd4;
        rd_addr[1] = 5'd9;
        #1;
        chk("flush_cnt", {26'd0, pending_cnt}, 32'd1);
        chk("flush_ready", {30'd0, rd_ready}, 32'd1);
        rd_addr[0] = 5'd6;
        rd_addr[1] = 5'd5;
        #1;
        chk("flush_x6", {31'd0, rd_ready[0]}, 32'd1);
        chk("flush_data", rd_data[1], 32'hCAFEF00D);
        flush = 1'b1;
        step();
        idle();
        chk("flush2_cnt", {26'd0, pending_cnt}, 32'd0);
        rsv_en   = 1'b1;
        rsv_addr = 5'd0;
        #1;
        chk("rsv0_ok", {31'd0, rsv_ok}, 32'd1);
        step();
        idle();
        chk("rsv0_cnt", {26'd0, pending_cnt}, 32'd0);

        // Same-cycle write and read of x8 (x8 reserved first)
        rsv_en   = 1'b1;
        rsv_addr = 5'd8;
        step();
        idle();
        wr_en      = 2'b01;
        wr_addr[0] = 5'd8;
        wr_data[0] = 32'hA5A5A5A5;
        rd_addr[0] = 5'd8;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_data", rd_data[0], 32'hA5A5A5A5);
        chk("byp_ready", {31'd0, rd_ready[0]}, 32'd1);
`else
        chk("byp_data", rd_data[0], 32'h0);
        chk("byp_ready", {31'd0, rd_ready[0]}, 32'd0);
`endif
        step();
        idle();
        #1;
        chk("x8_data", rd_data[0], 32'hA5A5A5A5);
        chk("x8_ready", {31'd0, rd_ready[0]}, 32'd1);
        chk("x8_cnt", {26'd0, pending_cnt}, 32'd0);

        // Asynchronous reset between edges, held over a busy edge
        rsv_en   = 1'b1;
        rsv_addr = 5'd13;
        step();
        idle();
        chk("rsv13_cnt", {26'd0, pending_cnt}, 32'd1);
        rd_addr[0] = 5'd5;
        rd_addr[1] = 5'd13;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_rd0", rd_data[0], 32'h0);
        chk("arst_rd1", rd_data[1], 32'h0);
        chk("arst_ready", {30'd0, rd_ready}, 32'd3);
        chk("arst_cnt", {26'd0, pending_cnt}, 32'd0);
        wr_en      = 2'b01;
        wr_addr[0] = 5'd7;
        wr_data[0] = 32'h00000077;
        rsv_en     = 1'b1;
        rsv_addr   = 5'd14;
        flush      = 1'b1;
        step();
        reset_n = 1'b1;
        idle();
        rd_addr[0] = 5'd7;
        rd_addr[1] = 5'd14;
        #1;
        chk("post_rst_x7", rd_data[0], 32'h0);
        chk("post_rst_ready", {30'd0, rd_ready}, 32'd3);
        chk("post_rst_cnt", {26'd0, pending_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
